// File: rtl/bank_latency_stats.sv
// bank_latency_stats: per-ID latency statistics for one memory bank.
// Tracks outstanding request IDs and accumulates matched response latency.
//
// Ports:
//   clk           sole clock
//   reset         synchronous, active-low
//   req_fire      request issued to the bank, ID on req_id
//   resp_fire     response returned by the bank, ID on resp_id
//   globalCycle   free-running 64-bit cycle count used as timestamp
//   clear         synchronous statistics clear (tag table kept)
//   rd_bin        histogram read index
//   rd_bin_count  registered count of histogram bin rd_bin
//   resp_count    matched responses
//   lat_sum       sum of matched latencies
//   lat_min       minimum matched latency (all-ones when none)
//   lat_max       maximum matched latency
//   orphan_count  responses with no outstanding entry
//   dup_count     requests to an already-outstanding ID
//   outstanding   number of valid tag-table entries
module bank_latency_stats #(
   parameter int ID_W      = 5,
   parameter int LAT_W     = 16,
   parameter int CNT_W     = 32,
   parameter int SUM_W     = 48,
   parameter int NUM_BINS  = 8,
   parameter int BIN_SHIFT = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_fire,
   input  logic [ID_W-1:0]             req_id,
   input  logic                        resp_fire,
   input  logic [ID_W-1:0]             resp_id,
   input  logic [63:0]                 globalCycle,
   input  logic                        clear,
   input  logic [$clog2(NUM_BINS)-1:0] rd_bin,
   output logic [CNT_W-1:0]            rd_bin_count,
   output logic [CNT_W-1:0]            resp_count,
   output logic [SUM_W-1:0]            lat_sum,
   output logic [LAT_W-1:0]            lat_min,
   output logic [LAT_W-1:0]            lat_max,
   output logic [CNT_W-1:0]            orphan_count,
   output logic [CNT_W-1:0]            dup_count,
   output logic [ID_W:0]               outstanding
);

   localparam int DEPTH  = 1 << ID_W;
   localparam int BIN_W  = $clog2(NUM_BINS);
   localparam int OUT_W  = ID_W + 1;
   localparam int SUMX_W = SUM_W + 1;
   localparam logic [63:0] LAT_MAX64 =
      64'((65'd1 << LAT_W) - 65'd1);

   // tag table
   logic              r_valid [DEPTH];
   logic [63:0]       r_stamp [DEPTH];
   logic [OUT_W-1:0]  r_outstanding;

   // stage 1: latency of a matched response
   logic              r_s1_vld;
   logic [LAT_W-1:0]  r_s1_lat;

   // statistics
   logic [CNT_W-1:0]  r_resp_cnt;
   logic [SUM_W-1:0]  r_lat_sum;
   logic [LAT_W-1:0]  r_lat_min;
   logic [LAT_W-1:0]  r_lat_max;
   logic [CNT_W-1:0]  r_orphan_cnt;
   logic [CNT_W-1:0]  r_dup_cnt;
   logic [CNT_W-1:0]  r_bin [NUM_BINS];
   logic [CNT_W-1:0]  r_rd_bin_cnt;

   logic              w_resp_hit;
   logic              w_orphan;
   logic              w_same_id;
   logic              w_dup;
   logic              w_inc;
   logic              w_dec;
   logic [63:0]       w_lat_full;
   logic [LAT_W-1:0]  w_lat_sat;
   logic [SUMX_W-1:0] w_sum_ext;
   logic [SUM_W-1:0]  w_sum_sat;
   logic [LAT_W-1:0]  w_bin_raw;
   logic [BIN_W-1:0]  w_bin_idx;

   function automatic logic [CNT_W-1:0] f_sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // All lookups use the pre-edge table, so a same-cycle request
   // on the response's ID never affects that response.
   always_comb begin
      w_resp_hit = resp_fire & r_valid[resp_id];
      w_orphan   = resp_fire & ~r_valid[resp_id];
      w_same_id  = (req_id == resp_id);
      // a request colliding with its own response is a re-issue,
      // not a duplicate
      w_dup      = req_fire & r_valid[req_id]
                 & ~(resp_fire & w_same_id);
      w_inc      = req_fire & ~r_valid[req_id];
      w_dec      = w_resp_hit & ~(req_fire & w_same_id);
   end

   assign w_lat_full = globalCycle - r_stamp[resp_id];
   assign w_lat_sat  = (w_lat_full > LAT_MAX64) ?
                       '1 : w_lat_full[LAT_W-1:0];

   assign w_sum_ext = {1'b0, r_lat_sum} + SUMX_W'(r_s1_lat);
   assign w_sum_sat = w_sum_ext[SUM_W] ?
                      '1 : w_sum_ext[SUM_W-1:0];

   always_comb begin
      w_bin_raw = r_s1_lat >> BIN_SHIFT;
      w_bin_idx = BIN_W'(NUM_BINS - 1);
      if (w_bin_raw <= LAT_W'(NUM_BINS - 1)) begin
         w_bin_idx = w_bin_raw[BIN_W-1:0];
      end
   end

   // Stamps need no reset: valid gates every use.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         r_stamp[req_id] <= globalCycle;
      end
   end

   // Request write is ordered after the response clear so it wins
   // on an ID collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
         end
         r_outstanding <= '0;
      end else begin
         if (w_resp_hit) begin
            r_valid[resp_id] <= 1'b0;
         end
         if (req_fire) begin
            r_valid[req_id] <= 1'b1;
         end
         unique case ({w_inc, w_dec})
            2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // Stage 1 always loads; clear only affects the statistics, so a
   // response caught by clear still lands one cycle later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1_vld <= 1'b0;
         r_s1_lat <= '0;
      end else begin
         r_s1_vld <= w_resp_hit;
         r_s1_lat <= w_lat_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_resp_cnt   <= '0;
         r_lat_sum    <= '0;
         r_lat_min    <= '1;
         r_lat_max    <= '0;
         r_orphan_cnt <= '0;
         r_dup_cnt    <= '0;
         r_rd_bin_cnt <= '0;
         for (int i = 0; i < NUM_BINS; i++) begin
            r_bin[i] <= '0;
         end
      end else begin
         r_rd_bin_cnt <= r_bin[rd_bin];
         if (clear) begin
            r_resp_cnt   <= '0;
            r_lat_sum    <= '0;
            r_lat_min    <= '1;
            r_lat_max    <= '0;
            r_orphan_cnt <= '0;
            r_dup_cnt    <= '0;
            for (int i = 0; i < NUM_BINS; i++) begin
               r_bin[i] <= '0;
            end
         end else begin
            if (r_s1_vld) begin
               r_resp_cnt <= f_sat_inc(r_resp_cnt);
               r_lat_sum  <= w_sum_sat;
               if (r_s1_lat < r_lat_min) begin
                  r_lat_min <= r_s1_lat;
               end
               if (r_s1_lat > r_lat_max) begin
                  r_lat_max <= r_s1_lat;
               end
               r_bin[w_bin_idx] <= f_sat_inc(r_bin[w_bin_idx]);
            end
            if (w_orphan) begin
               r_orphan_cnt <= f_sat_inc(r_orphan_cnt);
            end
            if (w_dup) begin
               r_dup_cnt <= f_sat_inc(r_dup_cnt);
            end
         end
      end
   end

   assign rd_bin_count = r_rd_bin_cnt;
   assign resp_count   = r_resp_cnt;
   assign lat_sum      = r_lat_sum;
   assign lat_min      = r_lat_min;
   assign lat_max      = r_lat_max;
   assign orphan_count = r_orphan_cnt;
   assign dup_count    = r_dup_cnt;
   assign outstanding  = r_outstanding;

endmodule

// File: tb/tb_bank_latency_stats.sv
// tb_bank_latency_stats: directed table, corner sequences and random
// traffic checked against an event-level reference model.
module tb_bank_latency_stats;

   localparam longint unsigned F = 65535;

   logic        clk;
   logic        reset;
   logic        req_fire;
   logic [4:0]  req_id;
   logic        resp_fire;
   logic [4:0]  resp_id;
   logic [63:0] globalCycle;
   logic        clear;
   logic [2:0]  rd_bin;
   logic [31:0] rd_bin_count;
   logic [31:0] resp_count;
   logic [47:0] lat_sum;
   logic [15:0] lat_min;
   logic [15:0] lat_max;
   logic [31:0] orphan_count;
   logic [31:0] dup_count;
   logic [5:0]  outstanding;

   int n_total = 0;
   int n_bad   = 0;

   bank_latency_stats dut (
      .clk          (clk),
      .reset        (reset),
      .req_fire     (req_fire),
      .req_id       (req_id),
      .resp_fire    (resp_fire),
      .resp_id      (resp_id),
      .globalCycle  (globalCycle),
      .clear        (clear),
      .rd_bin       (rd_bin),
      .rd_bin_count (rd_bin_count),
      .resp_count   (resp_count),
      .lat_sum      (lat_sum),
      .lat_min      (lat_min),
      .lat_max      (lat_max),
      .orphan_count (orphan_count),
      .dup_count    (dup_count),
      .outstanding  (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tg,
      input longint unsigned e_out, input longint unsigned e_resp,
      input longint unsigned e_sum, input longint unsigned e_min,
      input longint unsigned e_max, input longint unsigned e_orph,
      input longint unsigned e_dup, input longint unsigned e_rd);
      chk({tg, "_out"},  64'(outstanding),  e_out);
      chk({tg, "_resp"}, 64'(resp_count),   e_resp);
      chk({tg, "_sum"},  64'(lat_sum),      e_sum);
      chk({tg, "_min"},  64'(lat_min),      e_min);
      chk({tg, "_max"},  64'(lat_max),      e_max);
      chk({tg, "_orph"}, 64'(orphan_count), e_orph);
      chk({tg, "_dup"},  64'(dup_count),    e_dup);
      chk({tg, "_rd"},   64'(rd_bin_count), e_rd);
   endtask

   task automatic put(input bit rf, input int rid, input bit sf,
                      input int sid, input bit clr, input longint g);
      req_fire    = rf;
      req_id      = 5'(rid);
      resp_fire   = sf;
      resp_id     = 5'(sid);
      clear       = clr;
      globalCycle = 64'(g);
      tick();
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      longint unsigned lat;
      int              due;
   } pend_t;

   bit              m_v   [32];
   longint unsigned m_st  [32];
   pend_t           m_pq  [$];
   longint unsigned m_bin [8];
   longint unsigned m_resp, m_sum, m_min, m_max;
   longint unsigned m_orph, m_dup, m_rd;
   int              m_edge = 0;

   localparam longint unsigned CMAX = 64'hFFFF_FFFF;
   localparam longint unsigned SMAX = 64'hFFFF_FFFF_FFFF;

   function automatic longint unsigned sinc(input longint unsigned v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   function automatic void m_clear_stats();
      m_resp = 0; m_sum = 0; m_min = F; m_max = 0;
      m_orph = 0; m_dup = 0;
      foreach (m_bin[i]) m_bin[i] = 0;
   endfunction

   function automatic void m_record(input longint unsigned lat);
      longint unsigned b;
      m_resp = sinc(m_resp);
      m_sum  = (m_sum + lat > SMAX) ? SMAX : m_sum + lat;
      if (lat < m_min) m_min = lat;
      if (lat > m_max) m_max = lat;
      b = lat / 16;
      if (b > 7) b = 7;
      m_bin[b] = sinc(m_bin[b]);
   endfunction

   // Applies the spec's rules for the inputs present at the next edge.
   task automatic model_edge();
      pend_t keep [$];
      longint unsigned lat;
      bit orph_e;
      bit dup_e;
      m_edge++;
      if (!reset) begin
         foreach (m_v[i]) m_v[i] = 1'b0;
         m_pq.delete();
         m_clear_stats();
         m_rd = 0;
         return;
      end
      m_rd   = m_bin[rd_bin];
      orph_e = resp_fire && !m_v[resp_id];
      dup_e  = req_fire && m_v[req_id]
               && !(resp_fire && resp_id == req_id);
      if (clear) m_clear_stats();
      foreach (m_pq[k]) begin
         if (m_pq[k].due == m_edge) begin
            if (!clear) m_record(m_pq[k].lat);
         end else begin
            keep.push_back(m_pq[k]);
         end
      end
      m_pq = keep;
      if (!clear && orph_e) m_orph = sinc(m_orph);
      if (!clear && dup_e)  m_dup  = sinc(m_dup);
      if (resp_fire && m_v[resp_id]) begin
         lat = globalCycle - m_st[resp_id];
         if (lat > F) lat = F;
         m_pq.push_back('{lat, m_edge + 1});
         m_v[resp_id] = 1'b0;
      end
      if (req_fire) begin
         m_v[req_id]  = 1'b1;
         m_st[req_id] = globalCycle;
      end
   endtask

   function automatic longint unsigned m_out();
      longint unsigned n = 0;
      foreach (m_v[i]) n += longint'(m_v[i]);
      return n;
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      longint unsigned gc, rf, rid, sf, sid, clr, rb;
      longint unsigned e_out, e_resp, e_sum, e_min, e_max;
      longint unsigned e_orph, e_dup, e_rd;
   } vec_t;

   localparam int NV = 23;
   vec_t tv [NV];

   initial begin
      // gc rf id sf id clr rb | out resp sum min max orph dup rd
      tv[0]  = '{100,1,3,0,0,0,0,  1,0,0,F,0,0,0,0};
      tv[1]  = '{137,0,0,1,3,0,0,  0,0,0,F,0,0,0,0};
      tv[2]  = '{138,0,0,0,0,0,2,  0,1,37,37,37,0,0,0};
      tv[3]  = '{139,0,0,0,0,0,2,  0,1,37,37,37,0,0,1};
      tv[4]  = '{140,0,0,1,9,0,2,  0,1,37,37,37,1,0,1};
      tv[5]  = '{10,1,5,0,0,0,2,   1,1,37,37,37,1,0,1};
      tv[6]  = '{20,1,5,0,0,0,2,   1,1,37,37,37,1,1,1};
      tv[7]  = '{50,0,0,1,5,0,1,   0,1,37,37,37,1,1,0};
      tv[8]  = '{51,0,0,0,0,0,1,   0,2,67,30,37,1,1,0};
      tv[9]  = '{52,0,0,0,0,0,1,   0,2,67,30,37,1,1,1};
      tv[10] = '{0,1,7,0,0,0,2,    1,2,67,30,37,1,1,1};
      tv[11] = '{40,1,7,1,7,0,2,   1,2,67,30,37,1,1,1};
      tv[12] = '{41,0,0,0,0,0,2,   1,3,107,30,40,1,1,1};
      tv[13] = '{45,0,0,1,7,0,2,   0,3,107,30,40,1,1,2};
      tv[14] = '{46,0,0,0,0,0,0,   0,4,112,5,40,1,1,0};
      tv[15] = '{1000,1,1,0,0,0,0, 1,4,112,5,40,1,1,1};
      tv[16] = '{71000,0,0,1,1,0,0,0,4,112,5,40,1,1,1};
      tv[17] = '{71001,0,0,0,0,1,0,0,0,0,F,0,0,0,1};
      tv[18] = '{0,1,2,0,0,0,0,    1,0,0,F,0,0,0,0};
      tv[19] = '{70000,0,0,1,2,0,7,0,0,0,F,0,0,0,0};
      tv[20] = '{70001,0,0,0,0,0,7,0,1,F,F,F,0,0,0};
      tv[21] = '{70002,0,0,0,0,0,7,0,1,F,F,F,0,0,1};
      tv[22] = '{70003,0,0,0,0,0,2,0,1,F,F,F,0,0,0};

      reset = 1'b0;
      rd_bin = '0;
      put(0, 0, 0, 0, 0, 0);
      put(0, 0, 0, 0, 0, 1);
      chk_all("rst", 0, 0, 0, F, 0, 0, 0, 0);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         rd_bin = 3'(tv[i].rb);
         put(tv[i].rf != 0, int'(tv[i].rid), tv[i].sf != 0,
             int'(tv[i].sid), tv[i].clr != 0, longint'(tv[i].gc));
         chk_all($sformatf("v%0d", i), tv[i].e_out, tv[i].e_resp,
                 tv[i].e_sum, tv[i].e_min, tv[i].e_max,
                 tv[i].e_orph, tv[i].e_dup, tv[i].e_rd);
      end

      // clear vs stage-1 load, dup and orphan
      rd_bin = 3'd0;
      put(1, 4, 0, 0, 0, 200);
      chk("h1_out_a", 64'(outstanding), 1);
      put(1, 6, 0, 0, 0, 200);
      chk("h1_out_b", 64'(outstanding), 2);
      put(1, 6, 1, 4, 1, 210);
      chk("h1_dup_clr", 64'(dup_count), 0);
      chk("h1_out_c", 64'(outstanding), 1);
      chk("h1_resp_clr", 64'(resp_count), 0);
      chk("h1_min_clr", 64'(lat_min), F);
      put(0, 0, 0, 0, 0, 211);
      chk("h1_resp_s1", 64'(resp_count), 1);
      chk("h1_sum_s1", 64'(lat_sum), 10);
      chk("h1_min_s1", 64'(lat_min), 10);
      put(0, 0, 1, 9, 1, 212);
      chk("h1_orph_clr", 64'(orphan_count), 0);
      chk("h1_resp_clr2", 64'(resp_count), 0);
      put(0, 0, 1, 6, 0, 235);
      chk("h1_out_d", 64'(outstanding), 0);
      put(0, 0, 0, 0, 0, 236);
      chk("h1_dup_stamp", 64'(lat_sum), 25);

      // reset with 3 outstanding and one response in stage 1
      put(1, 10, 0, 0, 0, 300);
      put(1, 11, 0, 0, 0, 301);
      put(1, 12, 0, 0, 0, 302);
      put(1, 13, 0, 0, 0, 303);
      put(0, 0, 1, 13, 0, 310);
      chk("h2_out_pre", 64'(outstanding), 3);
      reset = 1'b0;
      put(0, 0, 0, 0, 0, 311);
      chk_all("h2_rst", 0, 0, 0, F, 0, 0, 0, 0);
      reset = 1'b1;
      put(0, 0, 0, 0, 0, 312);
      put(0, 0, 0, 0, 0, 313);
      chk("h2_resp_rel", 64'(resp_count), 0);
      chk("h2_out_rel", 64'(outstanding), 0);
      put(0, 0, 1, 10, 0, 320);
      put(0, 0, 1, 11, 0, 321);
      put(0, 0, 0, 0, 0, 322);
      put(0, 0, 0, 0, 0, 323);
      chk("h2_orph", 64'(orphan_count), 2);
      chk("h2_resp_post", 64'(resp_count), 0);

      // random traffic against the model
      reset = 1'b0;
      req_fire = 1'b0; resp_fire = 1'b0; clear = 1'b0;
      for (int i = 0; i < 2; i++) begin
         model_edge();
         tick();
      end
      reset = 1'b1;
      globalCycle = 64'd5000;
      for (int i = 0; i < 2500; i++) begin
         reset     = ($urandom_range(149) != 0);
         req_fire  = ($urandom_range(9) < 4);
         req_id    = 5'($urandom_range(7));
         resp_fire = ($urandom_range(9) < 4);
         resp_id   = 5'($urandom_range(7));
         clear     = ($urandom_range(39) == 0);
         rd_bin    = 3'($urandom_range(7));
         if ($urandom_range(29) == 0)
            globalCycle = globalCycle + 64'($urandom_range(90000));
         else
            globalCycle = globalCycle + 64'd1;
         model_edge();
         tick();
         chk_all("rnd", m_out(), m_resp, m_sum, m_min, m_max,
                 m_orph, m_dup, m_rd);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
